parity_check_rx: RTL and testbench
==================================

Name: parity_check_rx

Overview:
Receive-side companion to the team's 16-bit parity generator. It accepts a data word plus its transmitted parity bit over a valid/ready handshake and recomputes the parity. It forwards the word downstream with an error flag after one pipeline register. It also keeps link-health state: a saturating error counter and a consecutive-error alarm FSM. It sits at the sink end of any parity-protected 16-bit path.

Parameters:
DATA_W, 16, data word width; parity is the XOR of all DATA_W bits.
CNT_W, 8, width of the saturating error counter.
ALARM_THRESH, 4, number of consecutive errored words that raises alarm (range 1..255).

Ports:
clk  input  1  single clock; all state changes on the rising edge
rst  input  1  reset, synchronous and active-high
in_valid  input  1  upstream word valid
in_ready  output  1  block can accept a word this cycle
in_data  input  DATA_W  received data word
in_par  input  1  received parity bit (generator output)
out_valid  output  1  registered word available
out_ready  input  1  downstream accepts the word
out_data  output  DATA_W  registered copy of in_data
out_err  output  1  1 when the registered word failed parity
err_cnt  output  CNT_W  total errored words accepted, saturating
alarm  output  1  high while the FSM is in ALARM
clr  input  1  clears err_cnt and alarm state

Behaviour:
- Reset (rst=1 at an edge): out_valid=0, out_data=0, out_err=0, err_cnt=0, FSM=OK, alarm=0, run counter=0. Reset mid-transfer drops the held word with no replay.
- Handshake:
  - Accept occurs when in_valid && in_ready.
  - in_ready = !out_valid || out_ready, combinational. Full throughput, no bubbles.
  - in_ready does not depend on in_valid.
- Parity check:
  - err = (XOR of in_data) != in_par, using even parity: in_par must equal the XOR of the data.
  - Latency is 1 cycle from accept to out_valid.
- Output register:
  - On accept, load out_data=in_data and out_err=err, and set out_valid=1.
  - If out_valid && out_ready && !accept, then out_valid goes to 0.
  - out_data and out_err stay stable while out_valid && !out_ready.
- err_cnt:
  - Increments on each accepted errored word.
  - Holds at 2^CNT_W-1 once saturated; it never wraps.
- FSM (states OK, SUSPECT, ALARM) with run counter run:
  - OK: accepted error → SUSPECT with run=1. If ALARM_THRESH=1, go directly to ALARM.
  - SUSPECT: accepted error → run+1; when run+1 reaches ALARM_THRESH, go to ALARM. Accepted good word → OK with run=0.
  - ALARM: sticky. Good words do not leave it; only clr or rst exits to OK.
  - alarm = (state==ALARM), registered.
  - Cycles with no accept leave the FSM and run unchanged.
- clr:
  - Sets err_cnt=0, FSM=OK, run=0 next edge.
  - It has priority over a simultaneous accept. The errored word in that cycle is still output with out_err=1 but is not counted.
  - clr does not touch out_valid, out_data or out_err.
- rst has priority over clr.

Optional Feature:
PARITY_ODD_EN
- Defined: odd parity; err = (XOR of in_data) == in_par, i.e. expected bit is the inverted XOR.
- Undefined: even parity exactly as in Behaviour.
- All other behaviour is identical in both builds.

Decomposition:
- Package parity_pkg:
  - state enum (ST_OK, ST_SUSPECT, ST_ALARM);
  - default DATA_W=16;
  - CNT_W localparam default;
  - function for the expected parity bit, which honours PARITY_ODD_EN.
- One sub-module, par_reduce: combinational XOR reduction of DATA_W bits that yields the computed parity. It is reusable by the generator side.
- The top level holds the handshake register, counter and FSM.

Test Plan:
- Reset, then in_data=16'h0003, in_par=0, out_ready=1 → next cycle out_valid=1, out_data=16'h0003, out_err=0, err_cnt=0.
- in_data=16'h0001, in_par=0 → out_err=1, err_cnt=1, FSM=SUSPECT. Then a good word 16'h0000 with in_par=0 → FSM=OK, alarm=0.
- Four consecutive bad words (16'h0007, in_par=0), ALARM_THRESH=4 → alarm=1 after the 4th accept. Then 10 good words → alarm stays 1. Then clr=1 → alarm=0 and err_cnt=0.
- Backpressure: out_ready=0 while in_valid=1 → in_ready=0 and out_data held. Release out_ready → back-to-back words transfer one per cycle with none lost or duplicated.
- CNT_W=2: five errored words → err_cnt=3 (saturates, no wrap). A bad word accepted in the same cycle as clr → err_cnt=0 and out_err=1 on the output.
- Build with PARITY_ODD_EN: in_data=16'h0003, in_par=1 → out_err=0. in_par=0 → out_err=1.

Source files
------------

// File: rtl/parity_pkg.sv
// parity_pkg: shared types, defaults and parity helper for the parity receive path.
// Macro PARITY_ODD_EN selects odd parity in exp_par(); even parity otherwise.
package parity_pkg;
   typedef enum logic [1:0] {ST_OK, ST_SUSPECT, ST_ALARM} state_t;
   localparam int DATA_W_DEF = 16;
   localparam int CNT_W_DEF  = 8;
   localparam int RUN_W      = 8;
   // expected parity bit given the XOR of the data bits
   function automatic logic exp_par(input logic xr);
`ifdef PARITY_ODD_EN
      return ~xr;
`else
      return xr;
`endif
   endfunction
endpackage

// File: rtl/par_reduce.sv
// par_reduce: combinational XOR reduction of a data word.
// Ports: data (DATA_W) in, par out = XOR of all data bits.
module par_reduce #(
   parameter int DATA_W = 16
) (
   input  logic [DATA_W-1:0] data,
   output logic              par
);
   assign par = ^data;
endmodule

// File: rtl/parity_check_rx.sv
// parity_check_rx: parity checker with one-stage valid/ready output register,
// saturating error counter and consecutive-error alarm FSM.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_data/in_par upstream;
// out_valid/out_ready/out_data/out_err downstream; err_cnt, alarm status; clr.
// Macro PARITY_ODD_EN selects odd parity (default even).
module parity_check_rx
   import parity_pkg::*;
#(
   parameter int DATA_W       = DATA_W_DEF,
   parameter int CNT_W        = CNT_W_DEF,
   parameter int ALARM_THRESH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_par,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_err,
   output logic [CNT_W-1:0]  err_cnt,
   output logic              alarm,
   input  logic              clr
);
   logic             xr, err, accept;
   state_t           state_q, state_d;
   logic [RUN_W-1:0] run_q, run_d;
   logic [RUN_W:0]   run_inc;
   par_reduce #(.DATA_W(DATA_W)) u_red (.data(in_data), .par(xr));
   assign err      = in_par != exp_par(xr);
   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign run_inc  = {1'b0, run_q} + (RUN_W+1)'(1);
   assign alarm    = state_q == ST_ALARM;
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_err   <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_data  <= in_data;
         out_err   <= err;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end
   always_ff @(posedge clk) begin
      if (rst || clr)
         err_cnt <= '0;
      else if (accept && err && err_cnt != '1)
         err_cnt <= err_cnt + CNT_W'(1);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_OK;
         run_q   <= '0;
      end else begin
         state_q <= state_d;
         run_q   <= run_d;
      end
   end
   always_comb begin
      state_d = state_q;
      run_d   = run_q;
      if (clr) begin
         state_d = ST_OK;
         run_d   = '0;
      end else if (accept) begin
         case (state_q)
            ST_OK: if (err) begin
               run_d   = RUN_W'(1);
               state_d = (ALARM_THRESH == 1) ? ST_ALARM : ST_SUSPECT;
            end
            ST_SUSPECT: if (err) begin
               run_d   = run_inc[RUN_W-1:0];
               state_d = (run_inc >= (RUN_W+1)'(ALARM_THRESH)) ? ST_ALARM : ST_SUSPECT;
            end else begin
               run_d   = '0;
               state_d = ST_OK;
            end
            default: state_d = ST_ALARM;
         endcase
      end
   end
endmodule

// File: tb/tb_parity_check_rx.sv
// tb_parity_check_rx: scoreboard bench for parity_check_rx with a behavioural model.
module tb_parity_check_rx;
   localparam int DW = 16;
   localparam int CW = 3;
   localparam int TH = 4;
`ifdef PARITY_ODD_EN
   localparam bit ODD = 1'b1;
`else
   localparam bit ODD = 1'b0;
`endif
   logic clk = 0, rst = 1, in_valid = 0, in_ready, in_par = 0, out_valid, out_ready = 0;
   logic out_err, alarm, clr = 0;
   logic [DW-1:0] in_data = '0, out_data;
   logic [CW-1:0] err_cnt;
   int total = 0, bad = 0;
   logic [DW:0] q[$];
   bit m_valid, m_alarm;
   int m_cnt, m_run;

   parity_check_rx #(.DATA_W(DW), .CNT_W(CW), .ALARM_THRESH(TH)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_par(in_par), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_err(out_err), .err_cnt(err_cnt), .alarm(alarm), .clr(clr));

   always #5 clk = ~clk;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic logic gp(logic [DW-1:0] d);
      int ones = $countones(d);
      return logic'(ones % 2) ^ ODD;
   endfunction

   always @(negedge clk) begin
      if (out_valid === 1'b1) begin
         chk("q_has_item", q.size() != 0, 1);
         if (q.size() != 0) begin
            chk("out_data", out_data, q[0][DW-1:0]);
            chk("out_err", out_err, q[0][DW]);
            if (out_ready) void'(q.pop_front());
         end
      end
   end

   task automatic model_clear();
      m_valid = 0; m_alarm = 0; m_cnt = 0; m_run = 0;
   endtask

   task automatic do_reset();
      rst = 1; in_valid = 0; clr = 0; out_ready = 0;
      @(posedge clk); @(posedge clk); #1;
      rst = 0;
      q.delete();
      model_clear();
   endtask

   task automatic cycle(input logic v, input logic [DW-1:0] d, input logic p,
                        input logic o, input logic c);
      bit rdy, acc, e;
      in_valid = v; in_data = d; in_par = p; out_ready = o; clr = c;
      @(negedge clk);
      rdy = !m_valid || o;
      chk("in_ready", in_ready, rdy);
      chk("out_valid", out_valid, m_valid);
      chk("err_cnt", err_cnt, m_cnt);
      chk("alarm", alarm, m_alarm);
      acc = v && rdy;
      e = p != gp(d);
      if (acc) q.push_back({e, d});
      m_valid = acc ? 1'b1 : (m_valid && !o);
      if (c) begin
         m_cnt = 0; m_run = 0; m_alarm = 0;
      end else if (acc && e) begin
         if (m_cnt < 2**CW - 1) m_cnt++;
         m_run++;
         if (m_run >= TH) m_alarm = 1;
      end else if (acc && !m_alarm) begin
         m_run = 0;
      end
      @(posedge clk); #1;
   endtask

   initial begin
      logic [DW-1:0] d;
      model_clear();
      do_reset();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_err_cnt", err_cnt, 0);
      cycle(1, 16'h0003, gp(16'h0003), 1, 0);
      cycle(1, 16'h0001, ~gp(16'h0001), 1, 0);
      cycle(1, 16'h0000, gp(16'h0000), 1, 0);
      repeat (4) cycle(1, 16'h0007, ~gp(16'h0007), 1, 0);
      for (int i = 0; i < 10; i++) cycle(1, DW'(i * 3), gp(DW'(i * 3)), 1, 0);
      chk("alarm_sticky", alarm, 1);
      cycle(0, 0, 0, 1, 1);
      cycle(0, 0, 0, 1, 0);
      chk("clr_alarm", alarm, 0);
      chk("clr_cnt", err_cnt, 0);
      cycle(1, 16'h00aa, gp(16'h00aa), 1, 0);
      for (int i = 0; i < 3; i++) cycle(1, 16'h1234, gp(16'h1234), 0, 0);
      for (int i = 0; i < 5; i++) cycle(1, DW'(16'h5000 + i), gp(DW'(16'h5000 + i)), 1, 0);
      for (int i = 0; i < 10; i++) cycle(1, DW'(i), ~gp(DW'(i)), 1, 0);
      chk("sat_cnt", err_cnt, 2**CW - 1);
      cycle(1, 16'h0007, ~gp(16'h0007), 1, 1);
      cycle(0, 0, 0, 0, 0);
      chk("clr_win_cnt", err_cnt, 0);
      chk("clr_win_err", out_err, 1);
      cycle(0, 0, 0, 1, 0);
      cycle(1, 16'hbeef, gp(16'hbeef), 0, 0);
      cycle(1, 16'hcafe, gp(16'hcafe), 0, 0);
      do_reset();
      chk("midrst_valid", out_valid, 0);
      for (int i = 0; i < 600; i++) begin
         d = DW'($urandom);
         cycle($urandom_range(0, 3) != 0, d, gp(d) ^ ($urandom_range(0, 2) == 0),
               $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0);
      end
      repeat (3) cycle(0, 0, 0, 1, 0);
      chk("q_drained", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
